alu_operand_stage: RTL and testbench

//  ID/EX stage feeding the RISC-V ALU: 2-entry skid buffer of decoded ops, write-back forwarding, A/B operand muxing.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/alu_operand_stage_if.sv | 46 ++++
 rtl/alu_operand_stage_fwd_mux.sv | 33 +++
 rtl/alu_operand_stage.sv | 172 +++++++++++++++++
 tb/tb_alu_operand_stage.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V execute definitions: ALU operation codes, operand select codes,
// operand-stage occupancy states and default datapath widths.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int RA_W_DEFAULT = 5;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_EQ   = 5'd10;
    localparam logic [4:0] ALU_NE   = 5'd11;

    typedef enum logic [1:0] {A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2, A_RSVD = 2'd3} a_sel_e;
    typedef enum logic [1:0] {B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2, B_RSVD = 2'd3} b_sel_e;

    typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} stage_state_e;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode-side, write-back and EX-side signals of the ALU operand stage.
// master = surrounding pipeline, slave = the operand stage.
interface alu_operand_stage_if
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int RA_W = RA_W_DEFAULT
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [XLEN-1:0] in_pc_i;
    logic [RA_W-1:0] in_rs1_i;
    logic [RA_W-1:0] in_rs2_i;
    logic [XLEN-1:0] in_rs1_data_i;
    logic [XLEN-1:0] in_rs2_data_i;
    logic [XLEN-1:0] in_imm_i;
    logic [1:0]      in_a_sel_i;
    logic [1:0]      in_b_sel_i;
    logic [4:0]      in_alu_op_i;
    logic [RA_W-1:0] in_rd_i;
    logic            wb_we_i;
    logic [RA_W-1:0] wb_rd_i;
    logic [XLEN-1:0] wb_data_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] alu_a_o;
    logic [XLEN-1:0] alu_b_o;
    logic [4:0]      alu_op_o;
    logic [XLEN-1:0] store_data_o;
    logic [RA_W-1:0] out_rd_o;

    modport master (
        output in_valid_i, in_pc_i, in_rs1_i, in_rs2_i, in_rs1_data_i, in_rs2_data_i,
               in_imm_i, in_a_sel_i, in_b_sel_i, in_alu_op_i, in_rd_i,
               wb_we_i, wb_rd_i, wb_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, alu_a_o, alu_b_o, alu_op_o, store_data_o, out_rd_o
    );

    modport slave (
        input  in_valid_i, in_pc_i, in_rs1_i, in_rs2_i, in_rs1_data_i, in_rs2_data_i,
               in_imm_i, in_a_sel_i, in_b_sel_i, in_alu_op_i, in_rd_i,
               wb_we_i, wb_rd_i, wb_data_i, out_ready_i,
        output in_ready_o, out_valid_o, alu_a_o, alu_b_o, alu_op_o, store_data_o, out_rd_o
    );

endinterface

// File: rtl/alu_operand_stage_fwd_mux.sv
// Resolves one register operand: x0 reads as zero; with ALU_OPERAND_FWD_EN a
// matching write-back value replaces the stored register data.
module operand_fwd_mux #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] rs_addr_i,
    input  logic [XLEN-1:0] rs_data_i,
    input  logic            wb_we_i,
    input  logic [RA_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic [XLEN-1:0] data_o
);

    // A nonzero rs_addr match already implies wb_rd_i != 0.
    always_comb begin
        data_o = rs_data_i;
        if (rs_addr_i == '0) begin
            data_o = '0;
        end
`ifdef ALU_OPERAND_FWD_EN
        else if (wb_we_i && (wb_rd_i == rs_addr_i)) begin
            data_o = wb_data_i;
        end
`endif
    end

`ifndef ALU_OPERAND_FWD_EN
    logic unused_wb;
    assign unused_wb = ^{wb_we_i, wb_rd_i, wb_data_i};
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: two-deep skid buffer of decoded ops driving the ALU.
// ALU_OPERAND_FWD_EN: forward write-back data; otherwise interlock decode on RAW hazards.
module alu_operand_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int RA_W = RA_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    alu_operand_stage_if.slave bus
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [1:0]      a_sel;
        logic [1:0]      b_sel;
        logic [4:0]      alu_op;
    } entry_t;

    stage_state_e    state_q, state_d;
    logic            ready_q, ready_d;
    entry_t          entry_q [2];
    entry_t          entry_d [2];
    entry_t          in_entry;
    entry_t          src [3];
    entry_t          upd [3];
    logic [XLEN-1:0] fwd_rs1 [3];
    logic [XLEN-1:0] fwd_rs2 [3];
    logic            hazard, push, pop;

    always_comb begin
        in_entry = '{pc: bus.in_pc_i, rs1_data: bus.in_rs1_data_i, rs2_data: bus.in_rs2_data_i,
                     imm: bus.in_imm_i, rs1: bus.in_rs1_i, rs2: bus.in_rs2_i, rd: bus.in_rd_i,
                     a_sel: bus.in_a_sel_i, b_sel: bus.in_b_sel_i, alu_op: bus.in_alu_op_i};
        src[0] = entry_q[0];
        src[1] = entry_q[1];
        src[2] = in_entry;
    end

    // Slots 0/1 are the held entries, slot 2 is the op being captured this cycle.
    for (genvar gi = 0; gi < 3; gi++) begin : g_fwd
        operand_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_rs1 (
            .rs_addr_i (src[gi].rs1),
            .rs_data_i (src[gi].rs1_data),
            .wb_we_i   (bus.wb_we_i),
            .wb_rd_i   (bus.wb_rd_i),
            .wb_data_i (bus.wb_data_i),
            .data_o    (fwd_rs1[gi])
        );
        operand_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_rs2 (
            .rs_addr_i (src[gi].rs2),
            .rs_data_i (src[gi].rs2_data),
            .wb_we_i   (bus.wb_we_i),
            .wb_rd_i   (bus.wb_rd_i),
            .wb_data_i (bus.wb_data_i),
            .data_o    (fwd_rs2[gi])
        );
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            upd[i]          = src[i];
            upd[i].rs1_data = fwd_rs1[i];
            upd[i].rs2_data = fwd_rs2[i];
        end
    end

`ifdef ALU_OPERAND_FWD_EN
    assign hazard = 1'b0;
`else
    logic rs1_used, rs2_used;
    assign rs1_used = (bus.in_a_sel_i == A_RS1) && (bus.in_rs1_i != '0);
    assign rs2_used = (bus.in_b_sel_i == B_RS2) && (bus.in_rs2_i != '0);

    always_comb begin
        hazard = 1'b0;
        if (bus.wb_we_i && ((rs1_used && (bus.wb_rd_i == bus.in_rs1_i)) ||
                            (rs2_used && (bus.wb_rd_i == bus.in_rs2_i)))) begin
            hazard = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            if (((i == 0) ? (state_q != ST_EMPTY) : (state_q == ST_TWO)) &&
                ((rs1_used && (entry_q[i].rd == bus.in_rs1_i)) ||
                 (rs2_used && (entry_q[i].rd == bus.in_rs2_i)))) begin
                hazard = 1'b1;
            end
        end
    end
`endif

    // Flush wins over any handshake in the same cycle.
    assign push = bus.in_valid_i & bus.in_ready_o & ~flush_i;
    assign pop  = bus.out_valid_o & bus.out_ready_i & ~flush_i;

    always_comb begin
        state_d    = state_q;
        entry_d[0] = upd[0];
        entry_d[1] = upd[1];
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    entry_d[0] = upd[2];
                    state_d    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    entry_d[0] = upd[2];
                end else if (push) begin
                    entry_d[1] = upd[2];
                    state_d    = ST_TWO;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    entry_d[0] = upd[1];
                    state_d    = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush_i) begin
            state_d = ST_EMPTY;
        end
        ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            ready_q    <= 1'b1;
            entry_q[0] <= '0;
            entry_q[1] <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            entry_q[0] <= entry_d[0];
            entry_q[1] <= entry_d[1];
        end
    end

    assign bus.out_valid_o  = (state_q != ST_EMPTY);
    assign bus.in_ready_o   = ready_q & ~hazard;
    assign bus.alu_op_o     = entry_q[0].alu_op;
    assign bus.out_rd_o     = entry_q[0].rd;
    assign bus.store_data_o = entry_q[0].rs2_data;

    always_comb begin
        case (entry_q[0].a_sel)
            A_RS1:   bus.alu_a_o = entry_q[0].rs1_data;
            A_PC:    bus.alu_a_o = entry_q[0].pc;
            default: bus.alu_a_o = '0;
        endcase
        case (entry_q[0].b_sel)
            B_RS2:   bus.alu_b_o = entry_q[0].rs2_data;
            B_IMM:   bus.alu_b_o = entry_q[0].imm;
            B_FOUR:  bus.alu_b_o = XLEN'(4);
            default: bus.alu_b_o = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomised and directed bench for alu_operand_stage against a queue-based model
// of the stage; honours ALU_OPERAND_FWD_EN the same way the design does.
`timescale 1ns/1ps
module tb_alu_operand_stage;
    import riscv_pkg::*;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush_i = 1'b0;
    always #5 clk = ~clk;

    alu_operand_stage_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

    alu_operand_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd, op;
        logic [1:0]  asel, bsel;
    } op_t;

    op_t q[$];
    int  checks;
    int  errors;

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_a(op_t e);
        case (e.asel)
            2'd0:    return e.d1;
            2'd1:    return e.pc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] exp_b(op_t e);
        case (e.bsel)
            2'd0:    return e.d2;
            2'd1:    return e.imm;
            2'd2:    return 32'd4;
            default: return 32'd0;
        endcase
    endfunction

    // Register value an operand should carry after this clock edge.
    function automatic logic [31:0] resolve(logic [4:0] rs, logic [31:0] d);
        if (rs == 5'd0) return 32'd0;
`ifdef ALU_OPERAND_FWD_EN
        if (bus.wb_we_i && bus.wb_rd_i == rs) return bus.wb_data_i;
`endif
        return d;
    endfunction

    function automatic bit exp_hazard();
`ifdef ALU_OPERAND_FWD_EN
        return 1'b0;
`else
        bit u1, u2;
        u1 = (bus.in_a_sel_i == 2'd0) && (bus.in_rs1_i != 5'd0);
        u2 = (bus.in_b_sel_i == 2'd0) && (bus.in_rs2_i != 5'd0);
        if (bus.wb_we_i && ((u1 && bus.wb_rd_i == bus.in_rs1_i) || (u2 && bus.wb_rd_i == bus.in_rs2_i)))
            return 1'b1;
        foreach (q[i])
            if ((u1 && q[i].rd == bus.in_rs1_i) || (u2 && q[i].rd == bus.in_rs2_i))
                return 1'b1;
        return 1'b0;
`endif
    endfunction

    task automatic idle_inputs();
        bus.in_valid_i = 0; bus.in_pc_i = 0; bus.in_rs1_i = 0; bus.in_rs2_i = 0;
        bus.in_rs1_data_i = 0; bus.in_rs2_data_i = 0; bus.in_imm_i = 0;
        bus.in_a_sel_i = 0; bus.in_b_sel_i = 0; bus.in_alu_op_i = 0; bus.in_rd_i = 0;
        bus.wb_we_i = 0; bus.wb_rd_i = 0; bus.wb_data_i = 0;
        flush_i = 0;
    endtask

    task automatic set_op(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [1:0] asel, input logic [1:0] bsel,
                          input logic [4:0] op, input logic [4:0] rd);
        bus.in_valid_i = 1; bus.in_pc_i = pc; bus.in_rs1_i = rs1; bus.in_rs2_i = rs2;
        bus.in_rs1_data_i = d1; bus.in_rs2_data_i = d2; bus.in_imm_i = imm;
        bus.in_a_sel_i = asel; bus.in_b_sel_i = bsel; bus.in_alu_op_i = op; bus.in_rd_i = rd;
    endtask

    // Called at a negedge with inputs already driven; checks, advances model, ends at next negedge.
    task automatic step();
        bit  exp_rdy, push, pop;
        op_t inc, t;
        #1;
        exp_rdy = (q.size() != 2) && !exp_hazard();
        check_eq("in_ready", bus.in_ready_o, exp_rdy);
        check_eq("out_valid", bus.out_valid_o, q.size() != 0);
        if (q.size() != 0) begin
            check_eq("alu_a", bus.alu_a_o, exp_a(q[0]));
            check_eq("alu_b", bus.alu_b_o, exp_b(q[0]));
            check_eq("alu_op", bus.alu_op_o, q[0].op);
            check_eq("store_data", bus.store_data_o, q[0].d2);
            check_eq("out_rd", bus.out_rd_o, q[0].rd);
        end
        push = bus.in_valid_i && exp_rdy;
        pop  = (q.size() != 0) && bus.out_ready_i;
        inc.pc = bus.in_pc_i; inc.imm = bus.in_imm_i; inc.rs1 = bus.in_rs1_i; inc.rs2 = bus.in_rs2_i;
        inc.rd = bus.in_rd_i; inc.op = bus.in_alu_op_i; inc.asel = bus.in_a_sel_i; inc.bsel = bus.in_b_sel_i;
        inc.d1 = resolve(inc.rs1, bus.in_rs1_data_i);
        inc.d2 = resolve(inc.rs2, bus.in_rs2_data_i);
        foreach (q[i]) begin
            t = q[i];
            t.d1 = resolve(t.rs1, t.d1);
            t.d2 = resolve(t.rs2, t.d2);
            q[i] = t;
        end
        if (flush_i) begin
            q.delete();
        end else begin
            if (pop) begin
                $display("xfer rd=%0d op=%0d a=0x%08h b=0x%08h", q[0].rd, q[0].op, exp_a(q[0]), exp_b(q[0]));
                void'(q.pop_front());
            end
            if (push) q.push_back(inc);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        bus.out_ready_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_valid", bus.out_valid_o, 0);
        check_eq("rst_ready", bus.in_ready_o, 1);
        check_eq("rst_a", bus.alu_a_o, 0);
        check_eq("rst_b", bus.alu_b_o, 0);
        check_eq("rst_op", bus.alu_op_o, ALU_ADD);
        check_eq("rst_rd", bus.out_rd_o, 0);
        rst_n = 1;
        @(negedge clk);

        // Single op, one-cycle latency.
        set_op(32'h100, 5'd1, 5'd2, 32'd5, 32'd9, 32'd7, 2'd0, 2'd1, ALU_ADD, 5'd6);
        bus.out_ready_i = 1;
        step();
        idle_inputs();
        check_eq("lat_valid", bus.out_valid_o, 1);
        check_eq("lat_a", bus.alu_a_o, 5);
        check_eq("lat_b", bus.alu_b_o, 7);
        check_eq("lat_op", bus.alu_op_o, 0);
        step();

        // Backpressure: three offered, two accepted, drained in order.
        bus.out_ready_i = 0;
        for (int k = 0; k < 3; k++) begin
            set_op(32'h200 + 32'(4 * k), 5'd1, 5'd0, 32'(20 + k), 32'd0, 32'(k), 2'd0, 2'd1,
                   ALU_SUB, 5'(10 + k));
            step();
        end
        #1 check_eq("full_ready", bus.in_ready_o, 0);
        idle_inputs();
        bus.out_ready_i = 1;
        check_eq("order0", bus.out_rd_o, 10);
        step();
        check_eq("order1", bus.out_rd_o, 11);
        step();
        check_eq("drained", bus.out_valid_o, 0);

`ifdef ALU_OPERAND_FWD_EN
        // Held operand picks up write-back; x0 write-back ignored.
        bus.out_ready_i = 0;
        set_op(32'h300, 5'd3, 5'd0, 32'd1, 32'd0, 32'd0, 2'd0, 2'd0, ALU_OR, 5'd8);
        step();
        idle_inputs();
        bus.wb_we_i = 1; bus.wb_rd_i = 5'd3; bus.wb_data_i = 32'hAA;
        step();
        check_eq("fwd_a", bus.alu_a_o, 32'hAA);
        bus.wb_rd_i = 5'd0; bus.wb_data_i = 32'h55;
        step();
        check_eq("fwd_x0_a", bus.alu_a_o, 32'hAA);
        idle_inputs();
        bus.out_ready_i = 1;
        step();
`else
        // Interlock: reader of a held destination waits until it leaves.
        bus.out_ready_i = 0;
        set_op(32'h300, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 2'd1, 2'd2, ALU_OR, 5'd4);
        step();
        set_op(32'h304, 5'd0, 5'd4, 32'd0, 32'd33, 32'd0, 2'd2, 2'd0, ALU_AND, 5'd5);
        #1 check_eq("ilk_ready", bus.in_ready_o, 0);
        step();
        step();
        bus.out_ready_i = 1;
        step();
        #1 check_eq("ilk_release", bus.in_ready_o, 1);
        step();
        idle_inputs();
        step();
`endif

        // Flush with push and pop in the same cycle from ONE.
        bus.out_ready_i = 0;
        set_op(32'h400, 5'd1, 5'd2, 32'd1, 32'd2, 32'd3, 2'd1, 2'd1, ALU_XOR, 5'd7);
        step();
        set_op(32'h404, 5'd1, 5'd2, 32'd4, 32'd5, 32'd6, 2'd1, 2'd1, ALU_XOR, 5'd9);
        bus.out_ready_i = 1;
        flush_i = 1;
        step();
        idle_inputs();
        check_eq("flush_valid", bus.out_valid_o, 0);
        step();

        // Asynchronous reset while two entries are held.
        bus.out_ready_i = 0;
        set_op(32'h500, 5'd0, 5'd0, 32'd0, 32'd0, 32'd1, 2'd1, 2'd1, ALU_SLL, 5'd1);
        step();
        set_op(32'h504, 5'd0, 5'd0, 32'd0, 32'd0, 32'd2, 2'd1, 2'd1, ALU_SRL, 5'd2);
        step();
        idle_inputs();
        #2 rst_n = 0;
        #1;
        check_eq("arst_valid", bus.out_valid_o, 0);
        check_eq("arst_ready", bus.in_ready_o, 1);
        check_eq("arst_a", bus.alu_a_o, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1;

        // Random traffic.
        repeat (400) begin
            bus.in_valid_i    = ($urandom_range(0, 9) < 7);
            bus.in_pc_i       = $urandom;
            bus.in_rs1_i      = 5'($urandom_range(0, 7));
            bus.in_rs2_i      = 5'($urandom_range(0, 7));
            bus.in_rs1_data_i = $urandom;
            bus.in_rs2_data_i = $urandom;
            bus.in_imm_i      = $urandom;
            bus.in_a_sel_i    = 2'($urandom_range(0, 3));
            bus.in_b_sel_i    = 2'($urandom_range(0, 3));
            bus.in_alu_op_i   = 5'($urandom_range(0, 11));
            bus.in_rd_i       = 5'($urandom_range(0, 7));
            bus.wb_we_i       = 1'($urandom_range(0, 1));
            bus.wb_rd_i       = 5'($urandom_range(0, 7));
            bus.wb_data_i     = $urandom;
            bus.out_ready_i   = ($urandom_range(0, 9) < 6);
            flush_i           = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
